// File: rtl/uart_pkg.sv
// uart_pkg: declarations shared by uart_tx and uart_rx.
//   uart_state_t   : frame FSM states
//   clks_per_bit() : system clocks per bit time for a clock/baud pair
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake into the transmitter.
//   data  : byte to send
//   valid : producer has a byte on data
//   ready : transmitter FIFO can take a byte
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock synchronous FIFO with registered occupancy count.
//   clk, reset       : clock, async active-high reset (flushes contents)
//   wr_en, wr_data   : push; ignored while full
//   rd_en, rd_data   : pop; rd_data always shows the head entry
//   full, empty      : decoded from the registered count
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, LSB first, frames sent back-to-back.
//   clk, reset : clock, async active-high reset (aborts frame, flushes FIFO)
//   bus        : uart_tx_if.slave byte handshake (ready = FIFO not full)
//   tx         : registered serial line, idle high
//   busy       : FIFO non-empty or frame in progress
// Build option: define UART_TX_PARITY_EN to add a parity bit (sense from
// PARITY_ODD) after the data bits; otherwise frames are 8N1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 2_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy
);
  localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BAUD_LAST    = 16'(CLKS_PER_BIT - 1);

  uart_state_t state, state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  fifo_rd_data;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic        bit_done, tx_nxt;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.valid),
    .wr_data (bus.data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign bit_done  = (baud_cnt == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_SENSE = 1'(PARITY_ODD);
  logic parity_bit;

  // Parity is captured at pop because the shift register is consumed while sending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         parity_bit <= 1'b0;
    else if (fifo_pop) parity_bit <= ^fifo_rd_data ^ PARITY_SENSE;
  end
`else
  // Parity sense has no effect when no parity bit is sent.
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // tx_nxt is the line level for the current state; it is registered into tx,
  // so the line trails the state by one cycle without changing bit widths.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = START;
          fifo_pop  = 1'b1;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shift[0];
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt = parity_bit;
        if (bit_done) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            state_nxt = START;
            fifo_pop  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      tx <= tx_nxt;
      if (fifo_pop) begin
        shift    <= fifo_rd_data;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state != IDLE) begin
        if (bit_done) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (default 25 clocks per bit).
// A frame-level model (byte queue + bit list per frame) predicts tx, busy and
// ready every cycle; directed tests add hand-computed literal checks.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB        = 25;
  localparam int DEPTH      = 4;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FB         = 11;
  localparam int EXP_FRAME  = 275;
  localparam logic IDX9_55  = 1'b0;
`else
  localparam int FB         = 10;
  localparam int EXP_FRAME  = 250;
  localparam logic IDX9_55  = 1'b1;
`endif
  localparam int F = FB * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;
  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (2_000_000),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int         cyc = 0;
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  int         fstart = -100000;
  int         free = 0;
  int         acc_total = 0;
  logic       last_acc = 1'b0;
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
  logic       chk_en = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return (^b) ^ (PARITY_ODD != 0);
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic rdy_before;
    cyc++;
    last_acc = 1'b0;
    if (reset) begin
      q.delete();
      free   = 0;
      fstart = -100000;
    end else begin
      rdy_before = (q.size() < DEPTH);
      if (cyc >= free && q.size() > 0) begin
        cur    = q.pop_front();
        fstart = cyc + 1;
        free   = cyc + F;
      end
      if (bus.valid && rdy_before) begin
        q.push_back(bus.data);
        last_acc = 1'b1;
        acc_total++;
      end
    end
    exp_tx    = (cyc >= fstart && cyc < fstart + F) ? frame_bit(cur, (cyc - fstart) / CPB) : 1'b1;
    exp_busy  = (q.size() > 0) || (cyc < free);
    exp_ready = (q.size() < DEPTH);
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cmp_tx", tx, exp_tx);
      chk("cmp_busy", busy, exp_busy);
      chk("cmp_ready", bus.ready, exp_ready);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_one(input logic [7:0] b, output int n);
    bus.valid = 1'b1;
    bus.data  = b;
    @(negedge clk);
    n = cyc;
    bus.valid = 1'b0;
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, output int n);
    bus.valid = 1'b1;
    bus.data  = a;
    @(negedge clk);
    n = cyc;
    bus.data = b;
    @(negedge clk);
    bus.data = c;
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while ((busy || q.size() > 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk(name, (k < limit), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, got;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.ready, 1'b1);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // single byte 0x55 into idle block
    push_one(8'h55, n);
    wait_cyc(n + 1);   chk("b55_latency", tx, 1'b1);
    wait_cyc(n + 2);   chk("b55_start", tx, 1'b0);
    wait_cyc(n + 26);  chk("b55_start_last", tx, 1'b0);
    wait_cyc(n + 27);  chk("b55_bit0", tx, 1'b1);
    wait_cyc(n + 52);  chk("b55_bit1", tx, 1'b0);
    wait_cyc(n + 2 + 9 * CPB + 12); chk("b55_idx9", tx, IDX9_55);
    wait_cyc(n + EXP_FRAME);     chk("b55_busy_hi", busy, 1'b1);
    wait_cyc(n + EXP_FRAME + 1); chk("b55_busy_lo", busy, 1'b0);
    wait_idle("b55_idle", 4 * F);

    // 0x07: parity bit 1 (or stop bit 1 without parity)
    push_one(8'h07, n);
    wait_cyc(n + 2 + 9 * CPB + 12); chk("b07_idx9", tx, 1'b1);
    wait_idle("b07_idle", 4 * F);

    // burst of three on consecutive cycles
    push3(8'h00, 8'hFF, 8'hA5, n);
    wait_cyc(n + 1);          chk("burst_ready", bus.ready, 1'b1);
    wait_cyc(n + 2 + F - 1);  chk("burst_stop1", tx, 1'b1);
    wait_cyc(n + 2 + F);      chk("burst_start2", tx, 1'b0);
    wait_cyc(n + 2 + F + 25); chk("burst_ff_bit0", tx, 1'b1);
    wait_cyc(n + 2 + 2 * F);  chk("burst_start3", tx, 1'b0);
    wait_cyc(n + 2 + 2 * F + 50); chk("burst_a5_bit1", tx, 1'b0);
    wait_idle("burst_idle", 6 * F);

    // fill the FIFO while a frame is on the line
    push_one(8'h11, n);
    wait_cyc(n + 60);
    a0 = acc_total;
    bus.valid = 1'b1;
    bus.data  = 8'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (last_acc) bus.data = bus.data + 8'd1;
    end
    bus.valid = 1'b0;
    chk("fill_accepted", acc_total - a0, 4);
    chk("fill_ready_lo", bus.ready, 1'b0);
    wait_cyc(n + F);     chk("fill_ready_before_pop", bus.ready, 1'b0);
    wait_cyc(n + F + 1); chk("fill_ready_after_pop", bus.ready, 1'b1);
    wait_idle("fill_idle", 7 * F);

    // reset at bit 3 of 0x3C with two bytes queued
    push3(8'h3C, 8'h81, 8'h42, n);
    wait_cyc(n + 2 + 4 * CPB + 10);
    chk("rst_mid_bit3", tx, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", bus.ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_cyc(cyc + 3 * F);
    chk("rst_after_tx", tx, 1'b1);
    chk("rst_after_busy", busy, 1'b0);

    // back-to-back random bytes with valid held
    got = 0;
    bus.valid = 1'b1;
    bus.data  = 8'($urandom_range(0, 255));
    for (int k = 0; k < 30 * F && got < 24; k++) begin
      @(negedge clk);
      if (last_acc) begin
        got++;
        bus.data = 8'($urandom_range(0, 255));
      end
    end
    bus.valid = 1'b0;
    chk("rand_accepted", got, 24);
    wait_idle("rand_idle", 8 * F);

    chk("end_tx", tx, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_ready", bus.ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
